// File: rtl/svm_score_accumulator_if.sv
// ---------------------------------------------------------------------------
// svm_score_accumulator_if
// Bundles the partial-sum input stream and the window-score result bus of
// svm_score_accumulator.
//   iValid      partial sum valid (producer -> accumulator)
//   iPartial    FP32 partial sum from the adder tree
//   iClear      synchronous abort of the window in progress
//   oReady      accumulator can take iPartial this cycle
//   oValid      one-cycle pulse, score/detect/index valid
//   oScore      FP32 window score (sum of partials + bias)
//   oDetect     score strictly greater than +0
//   oWindowIdx  index of the window just scored
// master = producer/consumer side, slave = accumulator.
// ---------------------------------------------------------------------------
interface svm_score_accumulator_if #(
    parameter int IDX_W = 8
);
    logic             iValid;
    logic [31:0]      iPartial;
    logic             iClear;
    logic             oReady;
    logic             oValid;
    logic [31:0]      oScore;
    logic             oDetect;
    logic [IDX_W-1:0] oWindowIdx;

    modport master (
        output iValid, iPartial, iClear,
        input  oReady, oValid, oScore, oDetect, oWindowIdx
    );

    modport slave (
        input  iValid, iPartial, iClear,
        output oReady, oValid, oScore, oDetect, oWindowIdx
    );
endinterface

// File: rtl/svm_score_accumulator.sv
// ---------------------------------------------------------------------------
// svm_score_accumulator
// Accumulates NUM_PARTIALS FP32 partial dot-product sums into one SVM window
// score, adds the folded bias (threshold already subtracted) and emits the
// score, a detect flag and a wrapping window index.
// Ports:
//   iClk   clock, rising edge
//   iRst   synchronous active-high reset
//   bus    svm_score_accumulator_if.slave (partial stream in, score bus out)
// All additions go through one shared FP32 adder whose result is taken
// FPU_LAT cycles after its operands are launched.
// ---------------------------------------------------------------------------
module svm_score_accumulator #(
    parameter int          NUM_PARTIALS = 16,
    parameter logic [31:0] BIAS         = 32'hBF800000,
    parameter int          FPU_LAT      = 1,
    parameter int          IDX_W        = 8
) (
    input  logic                   iClk,
    input  logic                   iRst,
    svm_score_accumulator_if.slave bus
);
    localparam int CNT_W  = $clog2(NUM_PARTIALS + 1);
    localparam int WAIT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_ADD_WAIT, S_BIAS, S_BIAS_WAIT, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_acc;
    logic [31:0]       r_op_a, r_op_b;
    logic [IDX_W-1:0]  r_win;
    logic              r_valid, r_detect;
    logic [31:0]       r_score;
    logic [IDX_W-1:0]  r_idx;
    logic              w_ready, w_accept, w_wait_done, w_last;
    logic [31:0]       w_fpu_res;

    // FP32 add, round-to-nearest-even, subnormals kept, NaN/Inf passed on.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic        sa, sb;
        logic [7:0]  ea, eb, ea_e, eb_e, d;
        logic [26:0] ma, mb, mb_al;
        logic [27:0] sum;
        logic [9:0]  e;
        logic [24:0] mr;
        logic        rnd;
        // Order by magnitude so the result sign is always the larger operand's.
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        sa = a[31]; sb = b[31]; ea = a[30:23]; eb = b[30:23];
        if (ea == 8'hFF) begin
            if (a[22:0] != 23'd0 || (eb == 8'hFF && sa != sb)) return 32'h7FC00000;
            return a;
        end
        ea_e = (ea == 8'd0) ? 8'd1 : ea;
        eb_e = (eb == 8'd0) ? 8'd1 : eb;
        ma   = {(ea != 8'd0), a[22:0], 3'b000};
        mb   = {(eb != 8'd0), b[22:0], 3'b000};
        d    = ea_e - eb_e;
        // Align the smaller operand; shifted-out bits collapse into sticky.
        if (d >= 8'd27) begin
            mb_al = {26'd0, |mb};
        end else begin
            mb_al = mb >> d;
            if ((mb << (8'd27 - d)) != 27'd0) mb_al[0] = 1'b1;
        end
        if (sa == sb) sum = {1'b0, ma} + {1'b0, mb_al};
        else          sum = {1'b0, ma} - {1'b0, mb_al};
        // Exact cancellation gives +0; only -0 + -0 stays negative.
        if (sum == 28'd0) return (sa == sb) ? {sa, 31'd0} : 32'd0;
        e = {2'b00, ea_e};
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26] && e > 10'd1) begin
                    sum = sum << 1;
                    e   = e - 10'd1;
                end
            end
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (e >= 10'd255) return {sa, 8'hFF, 23'd0};
        return {sa, (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
    endfunction

    assign w_ready     = (r_state == S_IDLE || r_state == S_ACCUM) && !iRst;
    assign w_accept    = bus.iValid && w_ready && !bus.iClear;
    assign w_wait_done = (r_wait == WAIT_W'(FPU_LAT - 1));
    assign w_last      = (r_count == CNT_W'(NUM_PARTIALS));
    // Operands stay frozen for the whole wait, so the result is stable when sampled.
    assign w_fpu_res   = fp_add(r_op_a, r_op_b);

    assign bus.oReady     = w_ready;
    assign bus.oValid     = r_valid;
    assign bus.oScore     = r_score;
    assign bus.oDetect    = r_detect;
    assign bus.oWindowIdx = r_idx;

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = (NUM_PARTIALS == 1) ? S_BIAS : S_ACCUM;
            S_ACCUM:     if (w_accept) w_next = S_ADD_WAIT;
            S_ADD_WAIT:  if (w_wait_done) w_next = w_last ? S_BIAS : S_ACCUM;
            S_BIAS:      w_next = S_BIAS_WAIT;
            S_BIAS_WAIT: if (w_wait_done) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (bus.iClear) w_next = S_IDLE;
    end

    // Adder operand launch
    always_ff @(posedge iClk) begin
        if (!bus.iClear && r_state == S_ACCUM && w_accept) begin
            r_op_a <= r_acc;
            r_op_b <= bus.iPartial;
        end else if (!bus.iClear && r_state == S_BIAS) begin
            r_op_a <= r_acc;
            r_op_b <= BIAS;
        end
    end

    // Accumulator, counters and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_count  <= '0;
            r_wait   <= '0;
            r_acc    <= '0;
            r_win    <= '0;
            r_valid  <= 1'b0;
            r_score  <= '0;
            r_detect <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.iClear) begin
                r_count <= '0;
                r_wait  <= '0;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_acc   <= bus.iPartial;
                        r_count <= CNT_W'(1);
                    end
                    S_ACCUM: if (w_accept) begin
                        r_count <= r_count + CNT_W'(1);
                        r_wait  <= '0;
                    end
                    S_ADD_WAIT, S_BIAS_WAIT: begin
                        if (w_wait_done) r_acc  <= w_fpu_res;
                        else             r_wait <= r_wait + WAIT_W'(1);
                    end
                    S_BIAS: r_wait <= '0;
                    S_DONE: begin
                        r_valid  <= 1'b1;
                        r_score  <= r_acc;
                        r_detect <= ~r_acc[31] & (|r_acc[30:0]);
                        r_idx    <= r_win;
                        r_win    <= r_win + IDX_W'(1);
                        r_count  <= '0;
                    end
                    default: r_count <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_svm_score_accumulator.sv
// ---------------------------------------------------------------------------
// tb_svm_score_accumulator
// Bench for svm_score_accumulator with two configurations:
//   A: NUM_PARTIALS=4, BIAS=-2.0, FPU_LAT=2, IDX_W=2
//   B: NUM_PARTIALS=1, BIAS=-2.0, FPU_LAT=1, IDX_W=8
// Partials are multiples of 0.25, so every window score is exact in FP32 and
// the reference model works in integer quarter units.
// ---------------------------------------------------------------------------
module tb_svm_score_accumulator;
    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic rstA, rstB;
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0;
    int   validsA = 0, validsB = 0;
    int   idxA_model = 0, idxB_model = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    svm_score_accumulator_if #(.IDX_W(2)) busA();
    svm_score_accumulator_if #(.IDX_W(8)) busB();

    svm_score_accumulator #(.NUM_PARTIALS(4), .BIAS(32'hC0000000), .FPU_LAT(2), .IDX_W(2))
        dutA (.iClk(iClk), .iRst(rstA), .bus(busA));
    svm_score_accumulator #(.NUM_PARTIALS(1), .BIAS(32'hC0000000), .FPU_LAT(1), .IDX_W(8))
        dutB (.iClk(iClk), .iRst(rstB), .bus(busB));

    always @(negedge iClk) begin
        if (busA.oValid) validsA <= validsA + 1;
        if (busB.oValid) validsB <= validsB + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Exact FP32 encoding of q/4 (|q| < 2^23).
    function automatic logic [31:0] q_to_fp32(input int q);
        int          mag, p;
        logic [31:0] r;
        if (q == 0) return 32'h0;
        mag = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
        r[31]    = (q < 0);
        r[30:23] = 8'(p + 125);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h007FFFFF);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one partial to A; returns the edge number that accepted it.
    task automatic send_a(input logic [31:0] d, output int acc_edge);
        int n = 0;
        busA.iValid = 1'b1; busA.iPartial = d;
        while (!busA.oReady && n < 50) begin @(negedge iClk); n++; end
        check("A_ready", 32'(busA.oReady), 32'd1);
        acc_edge = cyc + 1;
        @(negedge iClk);
        busA.iValid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, output int acc_edge);
        int n = 0;
        busB.iValid = 1'b1; busB.iPartial = d;
        while (!busB.oReady && n < 50) begin @(negedge iClk); n++; end
        check("B_ready", 32'(busB.oReady), 32'd1);
        acc_edge = cyc + 1;
        @(negedge iClk);
        busB.iValid = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget, output int edge_no, output bit ok);
        ok = 1'b0; edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge iClk);
            if (busA.oValid) begin ok = 1'b1; edge_no = cyc; break; end
        end
    endtask

    task automatic wait_valid_b(input int budget, output int edge_no, output bit ok);
        ok = 1'b0; edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge iClk);
            if (busB.oValid) begin ok = 1'b1; edge_no = cyc; break; end
        end
    endtask

    // One full window on A with optional idle gaps; checked against the quarter-unit model.
    task automatic run_window_a(input string tag, input int q0, input int q1,
                                input int q2, input int q3, input int max_gap);
        int qs[4];
        int total, ae, ve;
        bit ok;
        qs = '{q0, q1, q2, q3};
        total = -8;
        ae = 0;
        for (int k = 0; k < 4; k++) begin
            total += qs[k];
            repeat ($urandom_range(0, max_gap)) @(negedge iClk);
            send_a(q_to_fp32(qs[k]), ae);
        end
        wait_valid_a(40, ve, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_score"}, busA.oScore, q_to_fp32(total));
        check({tag, "_detect"}, 32'(busA.oDetect), 32'(total > 0));
        check({tag, "_idx"}, 32'(busA.oWindowIdx), 32'(idxA_model));
        check({tag, "_lat"}, 32'(ve - ae), 32'd6);
        idxA_model = (idxA_model + 1) % 4;
        @(negedge iClk);
        check({tag, "_pulse"}, 32'(busA.oValid), 32'd0);
    endtask

    task automatic run_window_b(input string tag, input int q);
        int ae, ve;
        bit ok;
        send_b(q_to_fp32(q), ae);
        wait_valid_b(20, ve, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_score"}, busB.oScore, q_to_fp32(q - 8));
        check({tag, "_detect"}, 32'(busB.oDetect), 32'(q - 8 > 0));
        check({tag, "_idx"}, 32'(busB.oWindowIdx), 32'(idxB_model));
        check({tag, "_lat"}, 32'(ve - ae), 32'd3);
        idxB_model = (idxB_model + 1) % 256;
    endtask

    initial begin
        int ae[4];
        int k, ve, v0, a0, a1;
        bit ok;
        busA.iValid = 1'b0; busA.iPartial = '0; busA.iClear = 1'b0;
        busB.iValid = 1'b0; busB.iPartial = '0; busB.iClear = 1'b0;
        rstA = 1'b1; rstB = 1'b1;

        // Reset state
        repeat (2) @(negedge iClk);
        check("rst_A_ready", 32'(busA.oReady), 32'd0);
        check("rst_A_valid", 32'(busA.oValid), 32'd0);
        check("rst_A_score", busA.oScore, 32'd0);
        check("rst_A_detect", 32'(busA.oDetect), 32'd0);
        check("rst_A_idx", 32'(busA.oWindowIdx), 32'd0);
        check("rst_B_score", busB.oScore, 32'd0);
        rstA = 1'b0; rstB = 1'b0;
        @(negedge iClk);
        check("idle_A_ready", 32'(busA.oReady), 32'd1);

        // Directed windows
        run_window_a("t1", 4, 4, 4, 4, 0);
        check("t1_const", busA.oScore, 32'h40000000);
        run_window_a("t2a", 1, 1, 1, 1, 1);
        check("t2a_const", busA.oScore, 32'hBF800000);
        run_window_a("t2b", 2, 2, 2, 2, 0);
        check("t2b_const", busA.oScore, 32'h00000000);

        // Held iValid with an incrementing stream 1.0, 2.0, 3.0, 4.0
        k = 0;
        busA.iValid = 1'b1; busA.iPartial = q_to_fp32(4);
        for (int i = 0; i < 40 && k < 4; i++) begin
            if (busA.oReady) begin
                ae[k] = cyc + 1;
                k++;
                @(negedge iClk);
                if (k < 4) busA.iPartial = q_to_fp32(4 * (k + 1));
            end else begin
                @(negedge iClk);
            end
        end
        busA.iValid = 1'b0;
        check("t3_accepts", 32'(k), 32'd4);
        check("t3_gap01", 32'(ae[1] - ae[0]), 32'd1);
        check("t3_gap12", 32'(ae[2] - ae[1]), 32'd3);
        check("t3_gap23", 32'(ae[3] - ae[2]), 32'd3);
        wait_valid_a(40, ve, ok);
        check("t3_seen", 32'(ok), 32'd1);
        check("t3_lat", 32'(ve - ae[3]), 32'd6);
        check("t3_score", busA.oScore, 32'h41000000);
        check("t3_idx", 32'(busA.oWindowIdx), 32'(idxA_model));
        idxA_model = (idxA_model + 1) % 4;
        @(negedge iClk);

        // Abort after two partials; clear coincides with an acceptable partial
        v0 = validsA;
        send_a(q_to_fp32(4), a0);
        send_a(q_to_fp32(4), a1);
        for (int i = 0; i < 20 && !busA.oReady; i++) @(negedge iClk);
        busA.iClear = 1'b1; busA.iValid = 1'b1; busA.iPartial = 32'h42C80000;
        @(negedge iClk);
        busA.iClear = 1'b0; busA.iValid = 1'b0;
        check("t4_hold_score", busA.oScore, 32'h41000000);
        check("t4_ready", 32'(busA.oReady), 32'd1);
        run_window_a("t4", 4, 4, 4, 4, 0);
        check("t4_const", busA.oScore, 32'h40000000);
        check("t4_one_valid", 32'(validsA - v0), 32'd1);

        // Randomized windows
        for (int w = 0; w < 3; w++)
            run_window_a("rnd", int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
                         int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40, 2);

        // Reset while the first add of a window is in flight
        send_a(q_to_fp32(8), a0);
        send_a(q_to_fp32(8), a1);
        v0 = validsA;
        rstA = 1'b1;
        @(negedge iClk);
        check("t5_ready", 32'(busA.oReady), 32'd0);
        check("t5_valid", 32'(busA.oValid), 32'd0);
        check("t5_score", busA.oScore, 32'd0);
        check("t5_detect", 32'(busA.oDetect), 32'd0);
        check("t5_idx", 32'(busA.oWindowIdx), 32'd0);
        rstA = 1'b0;
        repeat (15) @(negedge iClk);
        check("t5_no_valid", 32'(validsA - v0), 32'd0);
        idxA_model = 0;
        run_window_a("t5w", 4, 4, 4, 4, 0);
        check("t5w_const", busA.oScore, 32'h40000000);

        // Index wrap 0,1,2,3,0 on the 2-bit counter
        for (int w = 1; w < 5; w++)
            run_window_a("wrap", int'($urandom_range(0, 40)), 3, 1, 2, 1);
        check("wrap_idx", 32'(busA.oWindowIdx), 32'd0);

        // Single-partial configuration
        run_window_b("t6", 12);
        check("t6_const", busB.oScore, 32'h3F800000);
        run_window_b("t6b", 4);
        run_window_b("t6c", 8);
        for (int w = 0; w < 3; w++) run_window_b("rndB", int'($urandom_range(0, 80)) - 40);

        // Held iValid on B: one window every FPU_LAT+3 cycles
        k = 0;
        busB.iValid = 1'b1; busB.iPartial = q_to_fp32(12);
        for (int i = 0; i < 40 && k < 2; i++) begin
            if (busB.oReady) begin ae[k] = cyc + 1; k++; end
            @(negedge iClk);
        end
        busB.iValid = 1'b0;
        check("t6_stream_accepts", 32'(k), 32'd2);
        check("t6_stream_gap", 32'(ae[1] - ae[0]), 32'd4);
        repeat (6) @(negedge iClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
